// File: rtl/sar_seq_ctrl.sv
// Successive-approximation sequencer: start arbitration, sample phase, per-bit DAC
// trials with programmable settle, result publication with a done pulse.
module sar_seq_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SETTLE_W   = 4,
  parameter int unsigned SAMPLE_CYC = 4,
  parameter bit          CMP_POL    = 1'b1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start_sw_i,
  input  logic                start_ext_i,
  input  logic                cont_i,
  input  logic                abort_i,
  input  logic [SETTLE_W-1:0] settle_i,
  input  logic                cmp_i,
  input  logic                ovr_clr_i,
  output logic [WIDTH-1:0]    dac_code_o,
  output logic                sample_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [WIDTH-1:0]    data_o,
  output logic                ovr_o
);

  localparam int unsigned SC_W  = $clog2(SAMPLE_CYC) + 1;
  localparam int unsigned CNT_W = (SETTLE_W > SC_W) ? SETTLE_W : SC_W;
  localparam int unsigned K_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SAMPLE, TRIAL, DONE} state_t;

  state_t              state;
  logic                ext_s1, ext_s2, ext_s3;
  logic [SETTLE_W-1:0] settle_q;
  logic [CNT_W-1:0]    cnt;
  logic [K_W-1:0]      k;
  logic [WIDTH-1:0]    acc;
  logic [WIDTH-1:0]    acc_next;
  logic [WIDTH-1:0]    bit_k;
  logic                start;

  assign start = start_sw_i | (ext_s2 & ~ext_s3);

  always_comb begin
    bit_k    = WIDTH'(1) << k;
    acc_next = (cmp_i == CMP_POL) ? (acc | bit_k) : acc;
  end

  // done_o/data_o are issued on the edge that leaves DONE, so an abort seen in
  // DONE still publishes, and back-to-back conversions stay exactly N cycles apart.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      ext_s1     <= 1'b0;
      ext_s2     <= 1'b0;
      ext_s3     <= 1'b0;
      settle_q   <= '0;
      cnt        <= '0;
      k          <= '0;
      acc        <= '0;
      dac_code_o <= '0;
      sample_o   <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      data_o     <= '0;
      ovr_o      <= 1'b0;
    end else begin
      ext_s1 <= start_ext_i;
      ext_s2 <= ext_s1;
      ext_s3 <= ext_s2;
      done_o <= 1'b0;

      if (ovr_clr_i)
        ovr_o <= 1'b0;
      if (start && (state == SAMPLE || state == TRIAL))
        ovr_o <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            settle_q   <= settle_i;
            cnt        <= CNT_W'(SAMPLE_CYC - 1);
            state      <= SAMPLE;
            busy_o     <= 1'b1;
            sample_o   <= 1'b1;
            dac_code_o <= '0;
          end
        end

        SAMPLE: begin
          if (abort_i) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            sample_o   <= 1'b0;
            dac_code_o <= '0;
          end else if (cnt == '0) begin
            state      <= TRIAL;
            k          <= K_W'(WIDTH - 1);
            acc        <= '0;
            cnt        <= CNT_W'(settle_q);
            sample_o   <= 1'b0;
            dac_code_o <= WIDTH'(1) << (WIDTH - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        TRIAL: begin
          if (abort_i) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            dac_code_o <= '0;
          end else if (cnt == '0) begin
            acc <= acc_next;
            if (k == '0) begin
              state      <= DONE;
              dac_code_o <= acc_next;
            end else begin
              k          <= k - 1'b1;
              cnt        <= CNT_W'(settle_q);
              dac_code_o <= acc_next | (bit_k >> 1);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          done_o <= 1'b1;
          data_o <= acc;
          if (!abort_i && (cont_i || start)) begin
            settle_q   <= settle_i;
            cnt        <= CNT_W'(SAMPLE_CYC - 1);
            state      <= SAMPLE;
            sample_o   <= 1'b1;
            dac_code_o <= '0;
          end else begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            sample_o   <= 1'b0;
            dac_code_o <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Directed bench for sar_seq_ctrl: comparator model, latency, continuous mode,
// overrun, abort, external start and asynchronous reset.
module tb_sar_seq_ctrl;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic       start_sw_i, start_ext_i, cont_i, abort_i, cmp_i, ovr_clr_i;
  logic [3:0] settle_i;
  logic [7:0] dac_code_o, data_o;
  logic       sample_o, busy_o, done_o, ovr_o;

  logic [7:0] vin;
  logic       cmp_force, cmp_val;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         t0, at, tprev;

  always #5 wb_clk_i = ~wb_clk_i;

  assign cmp_i = cmp_force ? cmp_val : (vin >= dac_code_o);

  sar_seq_ctrl #(
    .WIDTH     (8),
    .SETTLE_W  (4),
    .SAMPLE_CYC(4),
    .CMP_POL   (1'b1)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .start_sw_i (start_sw_i),
    .start_ext_i(start_ext_i),
    .cont_i     (cont_i),
    .abort_i    (abort_i),
    .settle_i   (settle_i),
    .cmp_i      (cmp_i),
    .ovr_clr_i  (ovr_clr_i),
    .dac_code_o (dac_code_o),
    .sample_o   (sample_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .data_o     (data_o),
    .ovr_o      (ovr_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge wb_clk_i);
    #1;
    cyc++;
  endtask

  task automatic pulse_sw;
    start_sw_i = 1'b1;
    tick();
    start_sw_i = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(output int when);
    when = -1000;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done_o) begin
        when = cyc;
        break;
      end
    end
  endtask

  task automatic no_done(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done_o) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    wb_rst_i = 1'b1;
    {start_sw_i, start_ext_i, cont_i, abort_i, ovr_clr_i, cmp_force, cmp_val} = '0;
    settle_i = 4'd1;
    vin      = 8'hA5;
    repeat (3) tick();
    check("reset_outputs", {dac_code_o, data_o, sample_o, busy_o, done_o, ovr_o}, 0);
    wb_rst_i = 1'b0;
    tick();

    // 1: comparator model, S=1
    pulse_sw();
    check("t1_sample_busy", {sample_o, busy_o, dac_code_o}, {2'b11, 8'h00});
    repeat (4) tick();
    check("t1_first_trial", {sample_o, dac_code_o}, {1'b0, 8'h80});
    wait_done(at);
    check("t1_latency", at - t0, 21);
    check("t1_data", data_o, 8'hA5);
    tick();
    check("t1_after_done", {done_o, busy_o, dac_code_o}, 0);

    // 2: comparator tied high then low, S=0
    settle_i  = 4'd0;
    cmp_force = 1'b1;
    cmp_val   = 1'b1;
    pulse_sw();
    wait_done(at);
    check("t2_latency_ones", at - t0, 13);
    check("t2_data_ones", data_o, 8'hFF);
    tick();
    cmp_val = 1'b0;
    pulse_sw();
    wait_done(at);
    check("t2_latency_zeros", at - t0, 13);
    check("t2_data_zeros", data_o, 8'h00);
    tick();
    cmp_force = 1'b0;

    // 4: continuous mode
    vin    = 8'h3C;
    cont_i = 1'b1;
    pulse_sw();
    wait_done(at);
    check("t4_first_latency", at - t0, 13);
    check("t4_first_data", data_o, 8'h3C);
    for (int i = 0; i < 2; i++) begin
      tprev = at;
      wait_done(at);
      check("t4_spacing", at - tprev, 13);
      check("t4_data", data_o, 8'h3C);
    end
    cont_i = 1'b0;
    tprev  = at;
    wait_done(at);
    check("t4_last_spacing", at - tprev, 13);
    tick();
    check("t4_idle_busy", busy_o, 1'b0);
    no_done("t4_stopped", 20);

    // 3: overrun while in TRIAL, S=1
    vin      = 8'hA5;
    settle_i = 4'd1;
    pulse_sw();
    repeat (8) tick();
    start_sw_i = 1'b1;
    tick();
    start_sw_i = 1'b0;
    check("t3_ovr_set", ovr_o, 1'b1);
    wait_done(at);
    check("t3_latency", at - t0, 21);
    check("t3_data", data_o, 8'hA5);
    tick();
    check("t3_no_restart", busy_o, 1'b0);

    pulse_sw();
    repeat (6) tick();
    start_sw_i = 1'b1;
    ovr_clr_i  = 1'b1;
    tick();
    start_sw_i = 1'b0;
    ovr_clr_i  = 1'b0;
    check("t3_set_beats_clr", ovr_o, 1'b1);
    ovr_clr_i = 1'b1;
    tick();
    ovr_clr_i = 1'b0;
    check("t3_clr", ovr_o, 1'b0);

    // 5: abort during bit-3 trial of the same conversion
    repeat (4) tick();
    check("t5_bit3_code", dac_code_o, 8'hA8);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("t5_abort_outputs", {busy_o, sample_o, dac_code_o}, 0);
    no_done("t5_no_done", 30);
    check("t5_data_kept", data_o, 8'hA5);

    // 6: external start coinciding with a software start
    vin         = 8'h5A;
    start_ext_i = 1'b1;
    tick();
    tick();
    check("t6_not_yet", busy_o, 1'b0);
    start_sw_i = 1'b1;
    tick();
    start_sw_i = 1'b0;
    t0 = cyc;
    check("t6_accept", busy_o, 1'b1);
    wait_done(at);
    check("t6_latency", at - t0, 21);
    check("t6_data", data_o, 8'h5A);
    tick();
    check("t6_single", {busy_o, ovr_o}, 0);

    start_ext_i = 1'b0;
    repeat (3) tick();
    start_ext_i = 1'b1;
    tick();
    tick();
    check("t6_ext_wait", busy_o, 1'b0);
    tick();
    check("t6_ext_accept", busy_o, 1'b1);
    repeat (10) tick();
    check("t6_mid_trial", busy_o, 1'b1);
    #2;
    wb_rst_i = 1'b1;
    #1;
    check("t6_async_reset", {dac_code_o, data_o, sample_o, busy_o, done_o, ovr_o}, 0);
    tick();
    wb_rst_i = 1'b0;
    start_ext_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
